pulse_stretcher: RTL and testbench

Converts single-cycle event pulses, such as the output of the calculator's button edge detectors, back into visible level signals. Each accepted event produces one output-high window of fixed length, followed by a mandatory low gap. Events that arrive while a window or gap is in progress are queued in a saturating pending counter and replayed in order. It sits between the key-press pulse path and the LED/buzzer feedback outputs on the Basys3 top level.

---
 rtl/pulse_stretcher.sv | 140 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event strobes into fixed-length high
// windows separated by a forced low gap. Events arriving while a window or
// gap is running are counted in a saturating pending queue and replayed.
// All outputs are registered copies of the internal state, so the visible
// window starts one cycle after the accepting edge.
module pulse_stretcher #(
    parameter int unsigned HIGH_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              drop
);

    localparam int unsigned MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              drop_d;

    logic              out_q, busy_q, drop_q;
    logic [PEND_W-1:0] pend_out_q;

    logic start, term, consumed, acc, dec;

    // Start decision, window/gap sequencing and pending-queue bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        drop_d   = 1'b0;
        start    = 1'b0;
        term     = (cnt_q == '0);

        case (state_q)
            S_IDLE: start = in;
            S_GAP:  start = term && ((pend_q != '0) || in);
            default: start = 1'b0;
        endcase

        // A strobe that itself launches a window with an empty queue is not
        // queued; otherwise it is queued and any start drains the queue head.
        consumed = start && in && (pend_q == '0);
        acc      = in && !consumed;
        dec      = start && (pend_q != '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            S_HIGH: begin
                if (term) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (start) begin
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LOAD;
                end else if (term) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (acc && !dec) begin
            if (pend_q == PEND_MAX) begin
                drop_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (dec && !acc) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    // Core state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Registered outputs derived from the core state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            pend_out_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            out_q      <= (state_q == S_HIGH);
            busy_q     <= (state_q != S_IDLE);
            pend_out_q <= pend_q;
            drop_q     <= drop_d;
        end
    end

    assign out     = out_q;
    assign busy    = busy_q;
    assign pending = pend_out_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: two instances, one with a short
// window (HIGH=4, GAP=2, PEND_W=3) and one for queue saturation
// (HIGH=8, GAP=2, PEND_W=2). Cycle c means the cycle after active edge c,
// where edge 0 is the edge sampling the first stimulus bit.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_in, b_in;
    logic       a_out, a_busy, a_drop;
    logic [2:0] a_pend;
    logic       b_out, b_busy, b_drop;
    logic [1:0] b_pend;

    int vectors = 0;
    int miscompares = 0;

    logic       obs_out  [64];
    logic       obs_busy [64];
    logic [2:0] obs_pend [64];
    logic       obs_drop [64];

    always #5 clk = ~clk;

    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(a_in),
        .out(a_out), .busy(a_busy), .pending(a_pend), .drop(a_drop)
    );

    pulse_stretcher #(.HIGH_CYCLES(8), .GAP_CYCLES(2), .PEND_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(b_in),
        .out(b_out), .busy(b_busy), .pending(b_pend), .drop(b_drop)
    );

    // Drives pat[i] so it is sampled at edge i and records the outputs of
    // cycle i (sampled on the following negedge).
    task automatic run(input int sel, input logic [63:0] pat, input int n);
        @(negedge clk);
        if (sel == 0) a_in = pat[0]; else b_in = pat[0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 0) begin
                obs_out[i] = a_out; obs_busy[i] = a_busy;
                obs_pend[i] = a_pend; obs_drop[i] = a_drop;
                a_in = (i + 1 < 64) ? pat[i+1] : 1'b0;
            end else begin
                obs_out[i] = b_out; obs_busy[i] = b_busy;
                obs_pend[i] = {1'b0, b_pend}; obs_drop[i] = b_drop;
                b_in = (i + 1 < 64) ? pat[i+1] : 1'b0;
            end
        end
        a_in = 1'b0;
        b_in = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_in = 1'b0;
        b_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_in = i[0];
            b_in = ~i[0];
            vectors++;
            if ({a_out, a_busy, a_pend, a_drop, b_out, b_busy, b_pend, b_drop} !== 11'b0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got a=%b%b%b%b b=%b%b%b%b required all zero",
                         i, a_out, a_busy, a_pend, a_drop, b_out, b_busy, b_pend, b_drop);
            end
        end
        a_in = 1'b0;
        b_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Enter HIGH, then reset asynchronously between edges.
        run(0, 64'h1, 3);
        vectors++;
        if (a_out !== 1'b1 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prehigh: got out=%b busy=%b required 1 1", a_out, a_busy);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (a_out !== 1'b0 || a_busy !== 1'b0 || a_pend !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_async_midhigh: got out=%b busy=%b pend=%0d required 0 0 0",
                     a_out, a_busy, a_pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [63:0] eo = 64'h1E;
        logic [63:0] eb = 64'h7E;
        run(0, 64'h1, 12);
        for (int c = 0; c < 12; c++) begin
            vectors++;
            if (obs_out[c] !== eo[c] || obs_busy[c] !== eb[c] || obs_pend[c] !== 3'd0 || obs_drop[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL single c=%0d: got out=%b busy=%b pend=%0d drop=%b required %b %b 0 0",
                         c, obs_out[c], obs_busy[c], obs_pend[c], obs_drop[c], eo[c], eb[c]);
            end
        end
    endtask

    task automatic test_queue;
        logic [63:0] eo = 64'h1E79E;
        logic [2:0]  ep;
        logic        eb;
        run(0, 64'h7, 22);
        for (int c = 0; c < 22; c++) begin
            if (c == 2) ep = 3'd1;
            else if (c >= 3 && c <= 6) ep = 3'd2;
            else if (c >= 7 && c <= 12) ep = 3'd1;
            else ep = 3'd0;
            eb = (c >= 1 && c <= 18);
            vectors++;
            if (obs_out[c] !== eo[c] || obs_busy[c] !== eb || obs_pend[c] !== ep || obs_drop[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL queue c=%0d: got out=%b busy=%b pend=%0d drop=%b required %b %b %0d 0",
                         c, obs_out[c], obs_busy[c], obs_pend[c], obs_drop[c], eo[c], eb, ep);
            end
        end
    endtask

    task automatic test_saturation;
        logic [63:0] eo = 64'h7F9FE7F9FE;
        logic [63:0] ed = 64'h30;
        logic [2:0]  ep;
        logic        eb;
        int          windows = 0;
        int          drops = 0;
        run(1, 64'h3F, 48);
        for (int c = 0; c < 48; c++) begin
            if (c == 2) ep = 3'd1;
            else if (c == 3) ep = 3'd2;
            else if (c >= 4 && c <= 10) ep = 3'd3;
            else if (c >= 11 && c <= 20) ep = 3'd2;
            else if (c >= 21 && c <= 30) ep = 3'd1;
            else ep = 3'd0;
            eb = (c >= 1 && c <= 40);
            if (obs_out[c] === 1'b1 && (c == 0 || obs_out[c-1] === 1'b0)) windows++;
            if (obs_drop[c] === 1'b1) drops++;
            vectors++;
            if (obs_out[c] !== eo[c] || obs_busy[c] !== eb || obs_pend[c] !== ep || obs_drop[c] !== ed[c]) begin
                miscompares++;
                $display("FAIL saturation c=%0d: got out=%b busy=%b pend=%0d drop=%b required %b %b %0d %b",
                         c, obs_out[c], obs_busy[c], obs_pend[c], obs_drop[c], eo[c], eb, ep, ed[c]);
            end
        end
        vectors++;
        if (windows != 4 || drops != 2) begin
            miscompares++;
            $display("FAIL saturation_counts: got windows=%0d drops=%0d required 4 2", windows, drops);
        end
    endtask

    task automatic test_gap_collision;
        logic [63:0] eo;
        logic [2:0]  ep;
        logic        eb;
        // Empty queue: the new strobe starts the next window directly.
        eo = 64'h79E;
        run(0, 64'h41, 16);
        for (int c = 0; c < 16; c++) begin
            eb = (c >= 1 && c <= 12);
            vectors++;
            if (obs_out[c] !== eo[c] || obs_busy[c] !== eb || obs_pend[c] !== 3'd0 || obs_drop[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL collision_empty c=%0d: got out=%b busy=%b pend=%0d drop=%b required %b %b 0 0",
                         c, obs_out[c], obs_busy[c], obs_pend[c], obs_drop[c], eo[c], eb);
            end
        end
        // One queued event: queued one starts, new one takes its place.
        eo = 64'h1E79E;
        run(0, 64'h43, 22);
        for (int c = 0; c < 22; c++) begin
            ep = (c >= 2 && c <= 12) ? 3'd1 : 3'd0;
            eb = (c >= 1 && c <= 18);
            vectors++;
            if (obs_out[c] !== eo[c] || obs_busy[c] !== eb || obs_pend[c] !== ep || obs_drop[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL collision_queued c=%0d: got out=%b busy=%b pend=%0d drop=%b required %b %b %0d 0",
                         c, obs_out[c], obs_busy[c], obs_pend[c], obs_drop[c], eo[c], eb, ep);
            end
        end
    endtask

    task automatic test_reset_midop;
        logic [63:0] eo = 64'h1E;
        logic [63:0] eb = 64'h7E;
        run(0, 64'h7, 6);
        vectors++;
        if (a_out !== 1'b0 || a_busy !== 1'b1 || a_pend !== 3'd2) begin
            miscompares++;
            $display("FAIL midop_pre: got out=%b busy=%b pend=%0d required 0 1 2", a_out, a_busy, a_pend);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (a_out !== 1'b0 || a_busy !== 1'b0 || a_pend !== 3'd0 || a_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset: got out=%b busy=%b pend=%0d drop=%b required 0 0 0 0",
                     a_out, a_busy, a_pend, a_drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 64'h1, 20);
        for (int c = 0; c < 20; c++) begin
            vectors++;
            if (obs_out[c] !== eo[c] || obs_busy[c] !== eb[c] || obs_pend[c] !== 3'd0 || obs_drop[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL midop_after c=%0d: got out=%b busy=%b pend=%0d drop=%b required %b %b 0 0",
                         c, obs_out[c], obs_busy[c], obs_pend[c], obs_drop[c], eo[c], eb[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_saturation();
        test_gap_collision();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
